// File: rtl/adder_pkg.sv
// Shared constants and cell-style selector for the hybrid ripple-carry adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_SPLIT = 4;

    // Two equivalent full-adder gate arrangements, kept separate so the
    // carry chain can be mixed for area/delay comparison.
    typedef enum logic {
        CELL_COMPRESSOR = 1'b0,
        CELL_OFA        = 1'b1
    } cell_style_t;

endpackage

// File: rtl/hybrid_rca8_adder_fa_cell.sv
// One-bit full adder; STYLE chooses the compressor or OFA gate arrangement.
module fa_cell
    import adder_pkg::*;
#(
    parameter cell_style_t STYLE = CELL_OFA
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic prop;

    assign prop = a ^ b;

    generate
        if (STYLE == CELL_COMPRESSOR) begin : g_compressor
            // Carry is a mux on propagate: pass cin when a!=b, else a (== b).
            assign s  = a ^ b ^ cin;
            assign co = prop ? cin : a;
        end else begin : g_ofa
            // Generate/propagate form of the carry.
            assign s  = prop ^ cin;
            assign co = (a & b) | (cin & prop);
        end
    endgenerate

endmodule

// File: rtl/hybrid_rca8_adder.sv
// Registered ripple-carry adder: low SPLIT bits use compressor cells, the
// rest use OFA cells. One-cycle latency, carry-in tied to zero.
module hybrid_rca8_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SPLIT = DEFAULT_SPLIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             valid_reg;

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            localparam cell_style_t BIT_STYLE =
                (gi < SPLIT) ? CELL_COMPRESSOR : CELL_OFA;

            fa_cell #(
                .STYLE (BIT_STYLE)
            ) u_cell (
                .a   (a[gi]),
                .b   (b[gi]),
                .cin (carry[gi]),
                .s   (sum_next[gi]),
                .co  (carry[gi+1])
            );
        end
    endgenerate

    // Capture the ripple result on valid input; otherwise hold it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else if (in_valid) begin
            sum_reg  <= sum_next;
            cout_reg <= carry[WIDTH];
        end
    end

    // out_valid pulses for exactly the cycle following an accepted operand pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
        end
    end

    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_hybrid_rca8_adder.sv
// Scoreboard bench: three adders (SPLIT=4, 0, 8) share one stimulus stream;
// a negedge monitor pops expected {cout,sum} on every out_valid.
module tb_hybrid_rca8_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         ov_m, ov_o, ov_c;
    logic [W-1:0] s_m, s_o, s_c;
    logic         c_m, c_o, c_c;

    int total;
    int bad;
    int txn;

    logic [W:0] exp_q[$];
    logic [W:0] last_res;

    hybrid_rca8_adder #(.WIDTH(W), .SPLIT(4)) dut_mix (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov_m), .sum(s_m), .cout(c_m)
    );

    hybrid_rca8_adder #(.WIDTH(W), .SPLIT(0)) dut_ofa (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov_o), .sum(s_o), .cout(c_o)
    );

    hybrid_rca8_adder #(.WIDTH(W), .SPLIT(8)) dut_cmp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov_c), .sum(s_c), .cout(c_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: on negedge, pop and compare when valid; otherwise check hold.
    always @(negedge clk) begin
        if (rst) begin
            last_res = '0;
        end else if (ov_m) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got %h expected nothing", {c_m, s_m});
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: {cout,sum}=%h expected=%h", txn, {c_m, s_m}, e);
                check("mix_result", {c_m, s_m}, e);
                check("ofa_result", {c_o, s_o}, e);
                check("cmp_result", {c_c, s_c}, e);
                check("ofa_valid", {8'h0, ov_o}, 9'h1);
                check("cmp_valid", {8'h0, ov_c}, 9'h1);
                last_res = e;
            end
        end else begin
            check("hold_mix", {c_m, s_m}, last_res);
            check("hold_ofa", {c_o, s_o}, last_res);
            check("hold_cmp", {c_c, s_c}, last_res);
            check("hold_valid", {6'h0, ov_m, ov_o, ov_c}, 9'h0);
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W:0] e);
        @(posedge clk);
        #1;
        in_valid = v;
        a        = ta;
        b        = tb;
        if (v) exp_q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        check(name, {c_m, s_m}, 9'h0);
        check({name, "_valid"}, {6'h0, ov_m, ov_o, ov_c}, 9'h0);
        check({name, "_others"}, {c_o, s_o} | {c_c, s_c}, 9'h0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        txn      = 0;
        last_res = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        #2;
        check_zero("reset_initial");
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle after release: must remain zero (monitor hold check).
        drive(1'b0, 8'h12, 8'h34, 9'h0);
        drive(1'b0, 8'h56, 8'h78, 9'h0);

        // Directed vectors, back-to-back.
        drive(1'b1, 8'b10110101, 8'b11101101, {1'b1, 8'b10100010});
        drive(1'b1, 8'b10110101, 8'b10100111, {1'b1, 8'b01011100});
        drive(1'b1, 8'b00101101, 8'b10100111, {1'b0, 8'b11010100});
        drive(1'b1, 8'hFF,       8'h01,       {1'b1, 8'h00});
        drive(1'b1, 8'h0F,       8'h01,       {1'b0, 8'h10});
        drive(1'b1, 8'h00,       8'h00,       {1'b0, 8'h00});
        drive(1'b1, 8'hFF,       8'hFF,       {1'b1, 8'hFE});
        drive(1'b1, 8'h80,       8'h80,       {1'b1, 8'h00});
        drive(1'b1, 8'h7F,       8'h01,       {1'b0, 8'h80});
        drive(1'b1, 8'h07,       8'h09,       {1'b0, 8'h10});

        // Hold with changing operands.
        drive(1'b0, 8'hAA, 8'h55, 9'h0);
        drive(1'b0, 8'hFF, 8'h01, 9'h0);
        drive(1'b0, 8'h3C, 8'hC3, 9'h0);

        drive(1'b1, 8'h5A, 8'hA5, {1'b0, 8'hFF});
        drive(1'b1, 8'hC8, 8'h64, {1'b1, 8'h2C});
        drive(1'b0, 8'h00, 8'h00, 9'h0);

        // Mid-operation asynchronous reset: the in-flight pair is discarded.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'h11;
        b        = 8'h22;
        #2 rst = 1'b1;
        #1;
        check_zero("reset_async");
        @(posedge clk);
        #1;
        check_zero("reset_held");
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        drive(1'b0, 8'h44, 8'h44, 9'h0);
        drive(1'b1, 8'h01, 8'h02, {1'b0, 8'h03});

        // Sweep: every a against a few boundary b values and an a-dependent b.
        for (int i = 0; i < 256; i++) begin
            logic [W-1:0] bv [5];
            bv[0] = 8'h00;
            bv[1] = 8'h01;
            bv[2] = 8'h80;
            bv[3] = 8'hFF;
            bv[4] = W'(i) ^ 8'h5A;
            for (int j = 0; j < 5; j++) begin
                drive(1'b1, W'(i), bv[j], {1'b0, W'(i)} + {1'b0, bv[j]});
            end
        end
        drive(1'b0, 8'h00, 8'h00, 9'h0);

        // Drain with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
